pattern_detector_param: RTL

PATTERN_DETECTOR_PARAM -- requirements
Module: pattern_detector_param

---
 rtl/pattern_detector_pkg.sv | 15 +
 rtl/pd_sat_counter.sv | 24 ++
 rtl/pattern_detector_param.sv | 100 ++++++++++
 3 files changed

// File: rtl/pattern_detector_pkg.sv
// Shared types and helpers for the serial pattern detector.
// State enum used by the detector FSM and the fill-counter width helper.
package pattern_detector_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } pd_state_t;

    // Width of a counter able to hold values 0..n inclusive.
    function automatic int unsigned fill_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once full; clr wins over inc.
module pd_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count register: reset, clear, or saturating increment.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector with selectable overlapping/non-overlapping
// matching and a registered one-cycle match pulse.
// Optional saturating match counter: define PATTERN_DETECTOR_MATCH_COUNT_EN.
module pattern_detector_param
    import pattern_detector_pkg::*;
#(
    parameter int unsigned           PAT_W   = 4,
    parameter int unsigned           CNT_W   = 8,
    parameter logic [PAT_W-1:0]      PAT_RST = {PAT_W{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pattern_load,
    input  logic             overlap_en,
    input  logic             count_clr,
    output logic             match
`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int unsigned    FW   = fill_width(PAT_W);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    pd_state_t         state, state_n;
    logic [FW-1:0]     fill, fill_n, fill_upd;
    logic [PAT_W-1:0]  history, history_n, hist_upd;
    logic [PAT_W-1:0]  pat_reg, pat_reg_n;
    logic              hit;

    // Candidate history/fill as if the current bit were accepted.
    always_comb begin
        hist_upd = {history[PAT_W-2:0], bit_in};
        fill_upd = (state == ARMED) ? FULL : fill + 1'b1;
    end

    // Next-state, history/fill update and hit detection.
    always_comb begin
        state_n   = state;
        fill_n    = fill;
        history_n = history;
        pat_reg_n = pat_reg;
        hit       = 1'b0;
        if (pattern_load) begin
            pat_reg_n = pattern;
            fill_n    = '0;
            state_n   = FILL;
        end else if (bit_valid) begin
            history_n = hist_upd;
            fill_n    = fill_upd;
            state_n   = (fill_upd == FULL) ? ARMED : FILL;
            if ((hist_upd == pat_reg) && (fill_upd == FULL)) begin
                hit = 1'b1;
                if (!overlap_en) begin
                    fill_n  = '0;
                    state_n = FILL;
                end
            end
        end
    end

    // State, datapath registers and registered match pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= FILL;
            fill    <= '0;
            history <= '0;
            pat_reg <= PAT_RST;
            match   <= 1'b0;
        end else begin
            state   <= state_n;
            fill    <= fill_n;
            history <= history_n;
            pat_reg <= pat_reg_n;
            match   <= hit;
        end
    end

`ifdef PATTERN_DETECTOR_MATCH_COUNT_EN
    pd_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (hit),
        .clr     (count_clr),
        .count   (match_count)
    );
`else
    // Counter absent: count_clr and CNT_W are intentionally left without a load.
    localparam int unsigned UNUSED_CNT_W = CNT_W;
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
`endif

endmodule
